// File: rtl/chip_control.sv
// chip_control: AXI4-Lite slave register bank for the chip configuration space.
// Register 0 is a read-only ID word; registers 1..NUM_REGS-1 are read/write.
// Independent write and read FSMs with registered handshakes.
// Optional build macro: CHIP_CONTROL_SLVERR_EN (out-of-range accesses answer SLVERR).
module chip_control #(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0000,
   parameter int unsigned           NUM_REGS   = 16,
   parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hB0A2_0001
) (
   input  logic                    clk,
   input  logic                    rst_n,
   // write address channel
   input  logic [ADDR_WIDTH-1:0]   aw_addr,
   input  logic [2:0]              aw_prot,
   input  logic                    aw_valid,
   output logic                    aw_ready,
   // write data channel
   input  logic [DATA_WIDTH-1:0]   w_data,
   input  logic [DATA_WIDTH/8-1:0] w_strb,
   input  logic                    w_valid,
   output logic                    w_ready,
   // write response channel
   output logic [1:0]              b_resp,
   output logic                    b_valid,
   input  logic                    b_ready,
   // read address channel
   input  logic [ADDR_WIDTH-1:0]   ar_addr,
   input  logic [2:0]              ar_prot,
   input  logic                    ar_valid,
   output logic                    ar_ready,
   // read data channel
   output logic [DATA_WIDTH-1:0]   r_data,
   output logic [1:0]              r_resp,
   output logic                    r_valid,
   input  logic                    r_ready
);

   localparam int unsigned           IDX_W  = $clog2(NUM_REGS);
   localparam logic [ADDR_WIDTH-1:0] SPAN   = ADDR_WIDTH'(NUM_REGS * 4);
   localparam logic [1:0]            OKAY   = 2'b00;
   localparam logic [1:0]            SLVERR = 2'b10;

`ifdef CHIP_CONTROL_SLVERR_EN
   localparam logic [1:0] MISS_RESP = SLVERR;
`else
   localparam logic [1:0] MISS_RESP = OKAY;
`endif

   localparam logic [1:0] W_IDLE = 2'd0;
   localparam logic [1:0] W_ACK  = 2'd1;
   localparam logic [1:0] W_RESP = 2'd2;

   localparam logic [1:0] R_IDLE = 2'd0;
   localparam logic [1:0] R_ACK  = 2'd1;
   localparam logic [1:0] R_DATA = 2'd2;

   logic [1:0]            w_state_q, w_state_d;
   logic [1:0]            r_state_q, r_state_d;
   logic                  aw_ready_q, w_ready_q, b_valid_q;
   logic [1:0]            b_resp_q;
   logic                  ar_ready_q, r_valid_q;
   logic [1:0]            r_resp_q;
   logic [DATA_WIDTH-1:0] r_data_q;
   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

   logic [ADDR_WIDTH-1:0] aw_off, ar_off;
   logic                  aw_hit, ar_hit;
   logic [IDX_W-1:0]      aw_idx, ar_idx;
   logic [DATA_WIDTH-1:0] rd_word;

   // Protection attributes carry no meaning for this block.
   logic unused_prot;
   assign unused_prot = ^{aw_prot, ar_prot};

   // Address decode for both channels; addresses below BASE_ADDR wrap and miss.
   always_comb begin
      aw_off  = aw_addr - BASE_ADDR;
      ar_off  = ar_addr - BASE_ADDR;
      aw_hit  = (aw_off < SPAN);
      ar_hit  = (ar_off < SPAN);
      aw_idx  = aw_off[IDX_W+1:2];
      ar_idx  = ar_off[IDX_W+1:2];
      rd_word = '0;
      if (ar_hit) rd_word = (ar_idx == '0) ? ID_VALUE : regs_q[ar_idx];
   end

   // Write FSM next-state: needs AW and W together, then waits for B acceptance.
   always_comb begin
      w_state_d = w_state_q;
      case (w_state_q)
         W_IDLE:  if (aw_valid && w_valid) w_state_d = W_ACK;
         W_ACK:   w_state_d = W_RESP;
         W_RESP:  if (b_ready) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   // Read FSM next-state: single-cycle address accept, then hold data until taken.
   always_comb begin
      r_state_d = r_state_q;
      case (r_state_q)
         R_IDLE:  if (ar_valid) r_state_d = R_ACK;
         R_ACK:   r_state_d = R_DATA;
         R_DATA:  if (r_ready) r_state_d = R_IDLE;
         default: r_state_d = R_IDLE;
      endcase
   end

   // Write channel state and registered handshakes (decoded from next state).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_state_q  <= W_IDLE;
         aw_ready_q <= 1'b0;
         w_ready_q  <= 1'b0;
         b_valid_q  <= 1'b0;
         b_resp_q   <= OKAY;
      end else begin
         w_state_q  <= w_state_d;
         aw_ready_q <= (w_state_d == W_ACK);
         w_ready_q  <= (w_state_d == W_ACK);
         b_valid_q  <= (w_state_d == W_RESP);
         if (w_state_q == W_ACK) b_resp_q <= aw_hit ? OKAY : MISS_RESP;
      end
   end

   // Register bank: byte-strobed commit on the edge that ends W_ACK; ID slot is never written.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else if (w_state_q == W_ACK && aw_hit && aw_idx != '0) begin
         for (int unsigned b = 0; b < DATA_WIDTH / 8; b++) begin
            if (w_strb[b]) regs_q[aw_idx][8*b +: 8] <= w_data[8*b +: 8];
         end
      end
   end

   // Read channel state; data captured from pre-edge register values, so a same-edge write is not seen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state_q  <= R_IDLE;
         ar_ready_q <= 1'b0;
         r_valid_q  <= 1'b0;
         r_data_q   <= '0;
         r_resp_q   <= OKAY;
      end else begin
         r_state_q  <= r_state_d;
         ar_ready_q <= (r_state_d == R_ACK);
         r_valid_q  <= (r_state_d == R_DATA);
         if (r_state_q == R_ACK) begin
            r_data_q <= rd_word;
            r_resp_q <= ar_hit ? OKAY : MISS_RESP;
         end
      end
   end

   assign aw_ready = aw_ready_q;
   assign w_ready  = w_ready_q;
   assign b_valid  = b_valid_q;
   assign b_resp   = b_resp_q;
   assign ar_ready = ar_ready_q;
   assign r_valid  = r_valid_q;
   assign r_data   = r_data_q;
   assign r_resp   = r_resp_q;

endmodule

// File: tb/tb_chip_control.sv
// Directed self-checking bench for chip_control.
module tb_chip_control;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] aw_addr = '0;
   logic [2:0]  aw_prot = '0;
   logic        aw_valid = 1'b0;
   logic        aw_ready;
   logic [31:0] w_data = '0;
   logic [3:0]  w_strb = '0;
   logic        w_valid = 1'b0;
   logic        w_ready;
   logic [1:0]  b_resp;
   logic        b_valid;
   logic        b_ready = 1'b0;
   logic [31:0] ar_addr = '0;
   logic [2:0]  ar_prot = '0;
   logic        ar_valid = 1'b0;
   logic        ar_ready;
   logic [31:0] r_data;
   logic [1:0]  r_resp;
   logic        r_valid;
   logic        r_ready = 1'b0;

   int checks = 0;
   int errors = 0;

`ifdef CHIP_CONTROL_SLVERR_EN
   localparam logic [1:0] MISS_RESP = 2'b10;
`else
   localparam logic [1:0] MISS_RESP = 2'b00;
`endif

   chip_control #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (32),
      .BASE_ADDR  (32'h0000_0000),
      .NUM_REGS   (16),
      .ID_VALUE   (32'hB0A2_0001)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .aw_addr(aw_addr), .aw_prot(aw_prot), .aw_valid(aw_valid), .aw_ready(aw_ready),
      .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
      .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
      .ar_addr(ar_addr), .ar_prot(ar_prot), .ar_valid(ar_valid), .ar_ready(ar_ready),
      .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready)
   );

   always #5 clk = ~clk;

   // Bus driver: full write with b_ready high; reports handshake observations.
   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int lat, output logic together,
                           output logic after, output logic to);
      to = 1'b0;
      @(negedge clk);
      aw_addr = a; w_data = d; w_strb = s;
      aw_valid = 1'b1; w_valid = 1'b1; b_ready = 1'b1;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!aw_ready && lat < 10);
      if (!aw_ready) to = 1'b1;
      together = aw_ready & w_ready;
      @(negedge clk);
      aw_valid = 1'b0; w_valid = 1'b0;
      after = aw_ready | w_ready;
      for (int n = 0; n < 10 && !b_valid; n++) @(negedge clk);
      if (!b_valid) to = 1'b1;
      resp = b_resp;
      @(negedge clk);
      b_ready = 1'b0;
   endtask

   // Bus driver: full read with r_ready high.
   task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                          output int lat, output logic to);
      to = 1'b0;
      @(negedge clk);
      ar_addr = a; ar_valid = 1'b1; r_ready = 1'b1;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!ar_ready && lat < 10);
      if (!ar_ready) to = 1'b1;
      @(negedge clk);
      ar_valid = 1'b0;
      for (int n = 0; n < 10 && !r_valid; n++) @(negedge clk);
      if (!r_valid) to = 1'b1;
      d = r_data; resp = r_resp;
      @(negedge clk);
      r_ready = 1'b0;
   endtask

   task automatic test_reset;
      logic [31:0] d; logic [1:0] rs; int lat; logic to;
      rst_n = 1'b0;
      repeat (100) @(negedge clk);
      checks++;
      if ({aw_ready, w_ready, b_valid, ar_ready, r_valid} !== 5'b0 || b_resp !== 2'b00 ||
          r_resp !== 2'b00 || r_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs: got rdy/vld=%b b_resp=%b r_resp=%b r_data=%h expected all zero",
                  {aw_ready, w_ready, b_valid, ar_ready, r_valid}, b_resp, r_resp, r_data);
      end
      rst_n = 1'b1;
      do_read(32'h00, d, rs, lat, to);
      checks++;
      if (to || d !== 32'hB0A2_0001 || rs !== 2'b00) begin
         errors++; $display("FAIL read_id: got %h/%b to=%b expected b0a20001/00", d, rs, to);
      end
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL read_latency: got %0d expected 1", lat); end
      do_read(32'h04, d, rs, lat, to);
      checks++;
      if (to || d !== 32'h0) begin errors++; $display("FAIL read_reg1_reset: got %h expected 0", d); end
   endtask

   task automatic test_basic_write;
      logic [31:0] d; logic [1:0] rs; int lat; logic tg, af, to;
      do_write(32'h04, 32'hDEAD_BEEF, 4'hF, rs, lat, tg, af, to);
      checks++;
      if (to || rs !== 2'b00) begin errors++; $display("FAIL write_resp: got %b to=%b expected 00", rs, to); end
      checks++;
      if (lat !== 1 || tg !== 1'b1 || af !== 1'b0) begin
         errors++;
         $display("FAIL write_ready_pulse: got lat=%0d together=%b after=%b expected 1/1/0", lat, tg, af);
      end
      do_read(32'h04, d, rs, lat, to);
      checks++;
      if (to || d !== 32'hDEAD_BEEF || rs !== 2'b00) begin
         errors++; $display("FAIL readback_04: got %h/%b expected deadbeef/00", d, rs);
      end
      // low address bits are ignored
      do_read(32'h07, d, rs, lat, to);
      checks++;
      if (to || d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL unaligned_07: got %h expected deadbeef", d); end
   endtask

   task automatic test_strobe;
      logic [31:0] d; logic [1:0] rs; int lat; logic tg, af, to;
      do_write(32'h08, 32'h1234_5678, 4'hF, rs, lat, tg, af, to);
      do_write(32'h08, 32'hFFFF_FFFF, 4'b0011, rs, lat, tg, af, to);
      do_read(32'h08, d, rs, lat, to);
      checks++;
      if (to || d !== 32'h1234_FFFF) begin errors++; $display("FAIL strobe_low: got %h expected 1234ffff", d); end
      do_write(32'h0C, 32'hAABB_CCDD, 4'b1010, rs, lat, tg, af, to);
      do_read(32'h0C, d, rs, lat, to);
      checks++;
      if (to || d !== 32'hAA00_CC00) begin errors++; $display("FAIL strobe_1010: got %h expected aa00cc00", d); end
   endtask

   task automatic test_id_write;
      logic [31:0] d; logic [1:0] rs; int lat; logic tg, af, to;
      do_write(32'h00, 32'h0, 4'hF, rs, lat, tg, af, to);
      checks++;
      if (to || rs !== 2'b00) begin errors++; $display("FAIL id_write_resp: got %b expected 00", rs); end
      do_read(32'h00, d, rs, lat, to);
      checks++;
      if (to || d !== 32'hB0A2_0001) begin errors++; $display("FAIL id_unchanged: got %h expected b0a20001", d); end
   endtask

   task automatic test_out_of_range;
      logic [31:0] d; logic [1:0] rs; int lat; logic tg, af, to;
      logic [31:0] exp;
      do_write(32'h40, 32'h1, 4'hF, rs, lat, tg, af, to);
      checks++;
      if (to || rs !== MISS_RESP) begin errors++; $display("FAIL oor_write_resp: got %b expected %b", rs, MISS_RESP); end
      do_read(32'h40, d, rs, lat, to);
      checks++;
      if (to || d !== 32'h0 || rs !== MISS_RESP) begin
         errors++; $display("FAIL oor_read: got %h/%b expected 0/%b", d, rs, MISS_RESP);
      end
      for (int unsigned a = 4; a < 64; a += 4) begin
         do_read(a, d, rs, lat, to);
         exp = (a == 4) ? 32'hDEAD_BEEF : (a == 8) ? 32'h1234_FFFF : (a == 12) ? 32'hAA00_CC00 : 32'h0;
         checks++;
         if (to || d !== exp || rs !== 2'b00) begin
            errors++; $display("FAIL bank_unchanged_%0h: got %h/%b expected %h/00", a, d, rs, exp);
         end
      end
   endtask

   // Write and read of the same register accepted on the same cycle: read sees the old value.
   task automatic test_concurrent;
      logic [31:0] d; logic [1:0] rs; int lat; logic to;
      @(negedge clk);
      aw_addr = 32'h0C; w_data = 32'hA5A5_A5A5; w_strb = 4'hF; ar_addr = 32'h0C;
      aw_valid = 1'b1; w_valid = 1'b1; ar_valid = 1'b1; b_ready = 1'b1; r_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (!(aw_ready && w_ready && ar_ready)) begin
         errors++; $display("FAIL concurrent_accept: got aw=%b w=%b ar=%b expected 1/1/1", aw_ready, w_ready, ar_ready);
      end
      @(negedge clk);
      aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
      checks++;
      if (!(b_valid && r_valid) || r_data !== 32'hAA00_CC00) begin
         errors++; $display("FAIL concurrent_old_value: got bv=%b rv=%b data=%h expected 1/1/aa00cc00", b_valid, r_valid, r_data);
      end
      @(negedge clk);
      b_ready = 1'b0; r_ready = 1'b0;
      do_read(32'h0C, d, rs, lat, to);
      checks++;
      if (to || d !== 32'hA5A5_A5A5) begin errors++; $display("FAIL concurrent_new_value: got %h expected a5a5a5a5", d); end
   endtask

   task automatic test_b_stall_and_reset;
      logic [31:0] d; logic [1:0] rs; int lat; logic to; logic stable;
      @(negedge clk);
      aw_addr = 32'h10; w_data = 32'h55; w_strb = 4'hF; aw_valid = 1'b1; w_valid = 1'b1; b_ready = 1'b0;
      for (int n = 0; n < 10 && !aw_ready; n++) @(negedge clk);
      @(negedge clk);
      // a second request is presented while B is stalled
      aw_addr = 32'h14; w_data = 32'h66;
      stable = 1'b1;
      for (int n = 0; n < 5; n++) begin
         if (!b_valid || b_resp !== 2'b00 || aw_ready || w_ready) stable = 1'b0;
         @(negedge clk);
      end
      checks++;
      if (!stable) begin errors++; $display("FAIL b_stall: got unstable response or new AW accepted expected held"); end
      aw_valid = 1'b0; w_valid = 1'b0; b_ready = 1'b1;
      @(negedge clk);
      b_ready = 1'b0;
      checks++;
      if (b_valid !== 1'b0) begin errors++; $display("FAIL b_release: got b_valid=%b expected 0", b_valid); end
      do_read(32'h14, d, rs, lat, to);
      checks++;
      if (to || d !== 32'h0) begin errors++; $display("FAIL stalled_aw_ignored: got %h expected 0", d); end
      // reset during R_DATA
      @(negedge clk);
      ar_addr = 32'h04; ar_valid = 1'b1; r_ready = 1'b0;
      for (int n = 0; n < 10 && !ar_ready; n++) @(negedge clk);
      @(negedge clk);
      ar_valid = 1'b0;
      checks++;
      if (r_valid !== 1'b1 || r_data !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL pre_reset_rdata: got rv=%b data=%h expected 1/deadbeef", r_valid, r_data);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (r_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_read: got r_valid=%b expected 0", r_valid); end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      do_read(32'h04, d, rs, lat, to);
      checks++;
      if (to || d !== 32'h0) begin errors++; $display("FAIL reg1_after_reset: got %h expected 0", d); end
      do_read(32'h00, d, rs, lat, to);
      checks++;
      if (to || d !== 32'hB0A2_0001) begin errors++; $display("FAIL id_after_reset: got %h expected b0a20001", d); end
   endtask

   initial begin
      test_reset();
      test_basic_write();
      test_strobe();
      test_id_write();
      test_out_of_range();
      test_concurrent();
      test_b_stall_and_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
